output_port_arbiter: RTL and testbench
======================================

OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 Parameter CREDIT_MAX, default 4, SHALL set the downstream buffer depth in flits (legal range 1..7).
REQ-002 Parameter WD_LIMIT, default 16, SHALL set the watchdog cycle count used only when ARB_WATCHDOG_EN is defined.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-005 req  input  5  SHALL carry per-input-port requests for this output: bit0 Local, 1 North, 2 East, 3 South, 4 West.
REQ-006 tail  input  5  SHALL flag that the flit currently presented by input i is the packet tail.
REQ-007 credit_ret  input  1  SHALL return one downstream buffer credit per asserted cycle.
REQ-008 select  output  5  SHALL be the one-hot crossbar select for the current owner; 5'b00000 when unowned.
REQ-009 locked  output  1  SHALL indicate that an owner holds the output.
REQ-010 fire  output  1  SHALL indicate that a flit transfers this cycle.
REQ-011 credits  output  3  SHALL report available downstream credits.
REQ-012 credit_err  output  1  SHALL be a sticky flag set on a credit overflow.

Function
REQ-013 The FSM SHALL have two states: IDLE (select=0, locked=0) and LOCKED (select=one-hot owner, locked=1).
REQ-014 In IDLE with req!=0, the block SHALL pick the first asserted bit scanning upward from rr_ptr with wrap 4->0, enter LOCKED, and register select; the grant appears the cycle after req is sampled (1-cycle latency).
REQ-015 In IDLE with req==0, the FSM SHALL remain in IDLE and select SHALL remain 5'b00000 (never X).
REQ-016 fire SHALL be combinational: locked AND req[owner] AND credits!=0.
REQ-017 In LOCKED, requests from non-owners SHALL be ignored; ownership SHALL persist until release (wormhole lock).
REQ-018 On fire with tail[owner]=1, the FSM SHALL return to IDLE next cycle and set rr_ptr = owner+1 mod 5; a single-flit packet (head=tail) SHALL release after one fire.
REQ-019 After release, the earliest next grant SHALL be one cycle later, giving one IDLE bubble cycle between packets.
REQ-020 In LOCKED, if req[owner]=0 or credits=0, fire SHALL be 0 and ownership SHALL be held.
REQ-021 credits SHALL update as follows: fire only -> -1; credit_ret only -> +1; both in the same cycle -> unchanged.
REQ-022 credit_ret alone at credits=CREDIT_MAX SHALL leave credits unchanged and set credit_err.
REQ-023 credits SHALL never underflow, guaranteed by REQ-016.
REQ-024 credit_err SHALL clear only on reset.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously force: FSM=IDLE, select=5'b00000, locked=0, rr_ptr=0, credits=CREDIT_MAX, credit_err=0, watchdog counter=0.
REQ-026 Reset asserted mid-packet SHALL drop ownership immediately, with no further fire.
REQ-027 The first arbitration after reset deassertion SHALL scan from bit0.

Configuration
REQ-028 The macro ARB_WATCHDOG_EN SHALL select a stall watchdog.
REQ-029 With ARB_WATCHDOG_EN defined:
- A counter SHALL increment each LOCKED cycle with req[owner]=0.
- The counter SHALL clear on any cycle with req[owner]=1.
- On reaching WD_LIMIT, the block SHALL force release to IDLE with rr_ptr=owner+1.
REQ-030 Without ARB_WATCHDOG_EN, no counter logic SHALL be present and ownership SHALL be held indefinitely per REQ-017.

Verification
REQ-031 Reset, then req=5'b10110 held -> grant order North(00010), East(00100), West(10000), North, each packet 1 flit with tail=1, 1 bubble between grants, credit_ret each fire.
REQ-032 req[2] 3-flit packet (tail on 3rd) while req[0] asserted -> select stays 00100 for all 3 fires, then 00000 for 1 cycle, then 00001.
REQ-033 CREDIT_MAX=4, owner streaming, no credit_ret -> 4 fires, credits 4->0, fire=0 with select held; one credit_ret -> exactly one more fire.
REQ-034 fire and credit_ret in the same cycle at credits=2 -> credits stays 2; credit_ret alone at credits=4 -> credits stays 4, credit_err=1 and sticky.
REQ-035 rst_n pulsed low mid-packet (owner East) -> select=00000 and locked=0 asynchronously; after release, req=5'b11111 -> Local granted first.
REQ-036 ARB_WATCHDOG_EN, WD_LIMIT=16: owner drops req for 16 cycles -> release on 16th count, rr_ptr advanced; without the macro -> still locked after 100 cycles.

Source files
------------

// File: rtl/output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : output_port_arbiter
// Description : Wormhole output-port arbiter for a 5-port mesh router.
//               Round-robin grant among Local/North/East/South/West requests,
//               lock held until the packet tail transfers, credit-based flow
//               control toward the downstream buffer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CREDIT_MAX  downstream buffer depth in flits (1..7)
//   WD_LIMIT    stall watchdog limit in cycles (used only with ARB_WATCHDOG_EN)
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req[4:0]    per-input requests (0 Local, 1 North, 2 East, 3 South, 4 West)
//   tail[4:0]   flit presented by input i is the packet tail
//   credit_ret  one downstream credit returned per asserted cycle
//   select[4:0] one-hot crossbar select of the owner, zero when unowned
//   locked      an owner holds the output
//   fire        a flit transfers this cycle (combinational)
//   credits     available downstream credits
//   credit_err  sticky credit-overflow flag, cleared only by reset
// Configuration
//   ARB_WATCHDOG_EN  when defined, an owner whose request stays low for
//                    WD_LIMIT consecutive locked cycles is forcibly released.
// ============================================================================
module output_port_arbiter #(
  parameter int CREDIT_MAX = 4,
  parameter int WD_LIMIT   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] req,
  input  logic [4:0] tail,
  input  logic       credit_ret,
  output logic [4:0] select,
  output logic       locked,
  output logic       fire,
  output logic [2:0] credits,
  output logic       credit_err
);

  localparam int         c_nports     = 5;
  localparam logic [2:0] c_credit_max = 3'(CREDIT_MAX);

  if (CREDIT_MAX < 1 || CREDIT_MAX > 7 || WD_LIMIT < 1) begin : g_bad_params
    $error("output_port_arbiter: CREDIT_MAX must be 1..7 and WD_LIMIT >= 1");
  end

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_owner;
  logic [2:0] w_owner_nxt;
  logic [4:0] r_select;
  logic [4:0] w_select_nxt;
  logic [2:0] r_rr_ptr;
  logic [2:0] w_rr_ptr_nxt;
  logic [2:0] r_credits;
  logic [2:0] w_credits_nxt;
  logic       r_credit_err;
  logic       w_credit_err_nxt;

  // Padded to 8 bits so a 3-bit index can never fall outside the vector.
  logic [7:0] w_req_ext;
  logic [7:0] w_tail_ext;
  logic       w_locked;
  logic       w_owner_req;
  logic       w_fire;
  logic       w_tail_release;
  logic       w_wd_release;
  logic [2:0] w_owner_plus1;
  logic       w_found;
  logic [2:0] w_grant_idx;
  logic [3:0] w_scan_idx;

  assign w_req_ext      = {3'b000, req};
  assign w_tail_ext     = {3'b000, tail};
  assign w_locked       = (r_state == ST_LOCKED);
  assign w_owner_req    = w_req_ext[r_owner];
  assign w_fire         = w_locked && w_owner_req && (r_credits != 3'd0);
  assign w_tail_release = w_fire && w_tail_ext[r_owner];
  assign w_owner_plus1  = (r_owner == 3'd4) ? 3'd0 : (r_owner + 3'd1);

  // --------------------------------------------------------------------------
  // Round-robin scan: first asserted request at or above rr_ptr, wrapping 4->0.
  // --------------------------------------------------------------------------
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = r_rr_ptr;
    w_scan_idx  = 4'd0;
    for (int i = 0; i < c_nports; i++) begin
      w_scan_idx = {1'b0, r_rr_ptr} + 4'(i);
      if (w_scan_idx >= 4'(c_nports)) begin
        w_scan_idx = w_scan_idx - 4'(c_nports);
      end
      if (!w_found && w_req_ext[w_scan_idx[2:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_scan_idx[2:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stall watchdog
  // --------------------------------------------------------------------------
`ifdef ARB_WATCHDOG_EN
  localparam int                c_wd_w    = $clog2(WD_LIMIT + 1);
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(WD_LIMIT - 1);

  logic [c_wd_w-1:0] r_wd_cnt;

  // The cycle that would bring the count to WD_LIMIT performs the release.
  assign w_wd_release = w_locked && !w_owner_req && (r_wd_cnt == c_wd_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (!w_locked || w_owner_req || w_wd_release) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end
`else
  assign w_wd_release = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Ownership FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_owner  <= 3'd0;
      r_select <= 5'b00000;
      r_rr_ptr <= 3'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_select <= w_select_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_select_nxt = r_select;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        w_select_nxt = 5'b00000;
        if (w_found) begin
          w_state_nxt  = ST_LOCKED;
          w_owner_nxt  = w_grant_idx;
          w_select_nxt = 5'b00001 << w_grant_idx;
        end
      end
      ST_LOCKED: begin
        // Non-owner requests are ignored until the owner releases.
        if (w_tail_release || w_wd_release) begin
          w_state_nxt  = ST_IDLE;
          w_select_nxt = 5'b00000;
          w_rr_ptr_nxt = w_owner_plus1;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_select_nxt = 5'b00000;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Credit counter. A send and a return in the same cycle cancel out; a lone
  // return at full credit is an overflow and is recorded, not counted.
  // --------------------------------------------------------------------------
  always_comb begin
    w_credits_nxt    = r_credits;
    w_credit_err_nxt = r_credit_err;
    case ({w_fire, credit_ret})
      2'b10: w_credits_nxt = r_credits - 3'd1;
      2'b01: begin
        if (r_credits == c_credit_max) begin
          w_credit_err_nxt = 1'b1;
        end else begin
          w_credits_nxt = r_credits + 3'd1;
        end
      end
      default: begin
        w_credits_nxt = r_credits;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits    <= c_credit_max;
      r_credit_err <= 1'b0;
    end else begin
      r_credits    <= w_credits_nxt;
      r_credit_err <= w_credit_err_nxt;
    end
  end

  assign select     = r_select;
  assign locked     = w_locked;
  assign fire       = w_fire;
  assign credits    = r_credits;
  assign credit_err = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_port_arbiter
// Description : Self-checking bench for output_port_arbiter. Stimulus pushes
//               the expected select/credits of every flit transfer into a
//               queue; a monitor pops and compares on each cycle with fire=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] req;
  logic [4:0] tail;
  logic       credit_ret;
  logic [4:0] select;
  logic       locked;
  logic       fire;
  logic [2:0] credits;
  logic       credit_err;

  typedef struct packed {
    logic [4:0] sel;
    logic [2:0] cr;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  output_port_arbiter #(
    .CREDIT_MAX (4),
    .WD_LIMIT   (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .tail       (tail),
    .credit_ret (credit_ret),
    .select     (select),
    .locked     (locked),
    .fire       (fire),
    .credits    (credits),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic expect_fire(input logic [4:0] s, input logic [2:0] c);
    q.push_back(exp_t'({s, c}));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every transfer must match the next queued expectation.
  always @(negedge clk) begin
    if (fire === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL fire_unexpected: got fire with select=%b, expected no fire", select);
      end else begin
        m_e = q.pop_front();
        check("fire_select", int'(select), int'(m_e.sel));
        check("fire_credits", int'(credits), int'(m_e.cr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  logic [4:0] rr_order [4];

  initial begin
    rr_order[0] = 5'b00010;
    rr_order[1] = 5'b00100;
    rr_order[2] = 5'b10000;
    rr_order[3] = 5'b00010;

    rst_n = 1'b0; req = '0; tail = '0; credit_ret = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_select", int'(select), 'b00000);
    check("rst_locked", int'(locked), 0);
    check("rst_credits", int'(credits), 4);
    check("rst_credit_err", int'(credit_err), 0);
    check("rst_fire", int'(fire), 0);

    // Round-robin order with single-flit packets and one bubble between them.
    cyc();
    rst_n = 1'b1; req = 5'b10110; tail = 5'b11111;
    for (int i = 0; i < 8; i++) begin
      credit_ret = i[0];
      if (i[0]) expect_fire(rr_order[i/2], 3'd4);
      @(negedge clk);
      if (i[0]) check("rr_locked", int'(locked), 1);
      else if (i > 0) begin
        check("rr_bubble_locked", int'(locked), 0);
        check("rr_bubble_select", int'(select), 'b00000);
      end
      cyc();
    end

    // 3-flit East packet while Local waits (rr_ptr=2 now).
    req = 5'b00101; tail = 5'b00000; credit_ret = 1'b0;
    cyc();
    credit_ret = 1'b1;
    expect_fire(5'b00100, 3'd4); cyc();
    expect_fire(5'b00100, 3'd4); cyc();
    tail = 5'b00100;
    expect_fire(5'b00100, 3'd4); cyc();
    tail = 5'b00000; credit_ret = 1'b0; req = 5'b00001;
    @(negedge clk);
    check("pkt_bubble_select", int'(select), 'b00000);
    check("pkt_bubble_locked", int'(locked), 0);
    cyc();

    // Local streams with no credit return until credits are exhausted.
    for (int i = 0; i < 4; i++) begin
      expect_fire(5'b00001, 3'(4 - i));
      if (i == 0) begin
        @(negedge clk);
        check("local_select", int'(select), 'b00001);
      end
      cyc();
    end
    @(negedge clk);
    check("stall_credits", int'(credits), 0);
    check("stall_fire", int'(fire), 0);
    check("stall_select", int'(select), 'b00001);
    cyc();
    credit_ret = 1'b1;
    @(negedge clk);
    check("stall_fire_ret", int'(fire), 0);
    cyc();
    credit_ret = 1'b0;
    expect_fire(5'b00001, 3'd1);
    cyc();
    req = 5'b00000; credit_ret = 1'b1;
    @(negedge clk);
    check("refill_credits0", int'(credits), 0);
    check("owner_held_select", int'(select), 'b00001);
    cyc();
    cyc();
    // Simultaneous send and return at credits=2.
    req = 5'b00001;
    expect_fire(5'b00001, 3'd2);
    cyc();
    @(negedge clk);
    check("both_credits", int'(credits), 2);
    tail = 5'b00001;
    expect_fire(5'b00001, 3'd2);
    cyc();
    req = 5'b00000; tail = 5'b00000;
    cyc();
    cyc();
    @(negedge clk);
    check("full_credits", int'(credits), 4);
    check("err_before", int'(credit_err), 0);
    cyc();
    credit_ret = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ovf_credits", int'(credits), 4);
      check("ovf_err_sticky", int'(credit_err), 1);
      cyc();
    end

    // Reset mid-packet with East owning (rr_ptr=1).
    req = 5'b00100;
    cyc();
    credit_ret = 1'b1;
    expect_fire(5'b00100, 3'd4); cyc();
    expect_fire(5'b00100, 3'd4);
    @(negedge clk);
    check("pre_rst_select", int'(select), 'b00100);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_select", int'(select), 'b00000);
    check("async_rst_locked", int'(locked), 0);
    check("async_rst_fire", int'(fire), 0);
    cyc();
    check("rst_credits2", int'(credits), 4);
    check("rst_err_clear", int'(credit_err), 0);
    rst_n = 1'b1; req = 5'b11111; credit_ret = 1'b0;
    cyc();
    expect_fire(5'b00001, 3'd4);
    @(negedge clk);
    check("post_rst_grant", int'(select), 'b00001);
    cyc();
    req = 5'b00000;

`ifdef ARB_WATCHDOG_EN
    repeat (15) cyc();
    @(negedge clk);
    check("wd_before_limit", int'(locked), 1);
    cyc();
    req = 5'b00011;
    @(negedge clk);
    check("wd_released", int'(locked), 0);
    check("wd_released_select", int'(select), 'b00000);
    cyc();
    @(negedge clk);
    check("wd_rr_advanced", int'(select), 'b00010);
    req = 5'b00000;
`else
    repeat (100) cyc();
    @(negedge clk);
    check("no_wd_locked", int'(locked), 1);
    check("no_wd_select", int'(select), 'b00001);
    cyc();
    req = 5'b00001; tail = 5'b00001;
    expect_fire(5'b00001, 3'd3);
    cyc();
    req = 5'b00011; tail = 5'b00000;
    cyc();
    @(negedge clk);
    check("rr_after_hold", int'(select), 'b00010);
    req = 5'b00000;
`endif

    repeat (3) cyc();
    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
